sram_arbiter: RTL and testbench

Two-master arbiter that shares one SRAM access port between the instruction-fetch unit and the MEM-stage data port. It latches each granted request, holds it on the memory-side port until the SRAM controller acknowledges it, returns read data with a one-cycle acknowledge pulse, and raises a stall to the pipeline while any request is outstanding. A watchdog aborts memory accesses that are never acknowledged.

---
 rtl/sram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM port between instruction fetch and the MEM-stage
// data port. Grants one request at a time, holds it on the mem_* port until the
// controller acks it, returns a one-cycle ack with read data, and aborts accesses
// that the controller never acknowledges.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_ack_o,
  // data port
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_ack_o,
  // SRAM controller port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // status
  output logic              err_o,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // watchdog terminal count; counter is cleared on every grant so it never wraps
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic       last_d;      // 1 = data was granted last, 0 = fetch (reset value)
  logic [7:0] wdog;
  logic       inst_elig, data_elig;
  logic       grant_i, grant_d;
  logic       done, abort;

  // A request whose ack is pulsing this cycle is the one just served; don't re-grant it.
  assign inst_elig = inst_req_i & ~inst_ack_o;
  assign data_elig = data_req_i & ~data_ack_o;

  assign stall_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);

  // Next-state and grant decode: alternate on ties, finish on ack or watchdog expiry.
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (inst_elig && data_elig) begin
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
        end else if (inst_elig) begin
          grant_i = 1'b1;
        end else if (data_elig) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_n = BUSY_I;
        if (grant_d) state_n = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack_i) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (wdog == WDOG_LAST) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Remember who won the last grant so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (!rst)         last_d <= 1'b0;
    else if (grant_d) last_d <= 1'b1;
    else if (grant_i) last_d <= 1'b0;
  end

  // Watchdog: counts un-acked busy cycles, restarts on each grant.
  always_ff @(posedge clk) begin
    if (!rst)                         wdog <= '0;
    else if (grant_i || grant_d)      wdog <= '0;
    else if (state != IDLE && !mem_ack_i) wdog <= wdog + 8'd1;
  end

  // Memory-side port: latched on grant and held steady for the whole access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b0000;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (grant_i) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'b1111;
      mem_addr_o  <= inst_addr_i;
      mem_wdata_o <= '0;
    end else if (grant_d) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= data_we_i;
      mem_be_o    <= data_be_i;
      mem_addr_o  <= data_addr_i;
      mem_wdata_o <= data_wdata_i;
    end else if (done || abort) begin
      mem_req_o   <= 1'b0;
    end
  end

  // Requester side: one-cycle ack/err pulse, read data only for a completed read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_ack_o   <= 1'b0;
      inst_rdata_o <= '0;
      data_ack_o   <= 1'b0;
      data_rdata_o <= '0;
      err_o        <= 1'b0;
    end else begin
      inst_ack_o   <= 1'b0;
      inst_rdata_o <= '0;
      data_ack_o   <= 1'b0;
      data_rdata_o <= '0;
      err_o        <= abort;
      if (done || abort) begin
        if (state == BUSY_I) begin
          inst_ack_o <= 1'b1;
          if (done) inst_rdata_o <= mem_rdata_i;
        end else begin
          data_ack_o <= 1'b1;
          if (done && !mem_we_o) data_rdata_o <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios followed by randomized traffic checked
// against a small model (word memory + alternate-on-tie grant rule).
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inst_req_i = 1'b0;
  logic [AW-1:0] inst_addr_i = '0;
  logic [DW-1:0] inst_rdata_o;
  logic          inst_ack_o;
  logic          data_req_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = 4'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic [DW-1:0] data_rdata_o;
  logic          data_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          err_o;
  logic          stall_o;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_rdata_o(inst_rdata_o), .inst_ack_o(inst_ack_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  logic [DW-1:0] mem_m [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called in the cycle mem_req_o first shows high: waits n cycles, then acks.
  // Returns in the ack cycle (k+1).
  task automatic serve(input int n, input logic [DW-1:0] rd);
    for (int i = 0; i < n; i++) step();
    mem_ack_i   = 1'b1;
    mem_rdata_i = rd;
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int            cnt;
    bit            pi, pd, first_d, g_d, last_m, st_exp;
    logic [3:0]    ia, da, dbe;
    logic          dwe;
    logic [DW-1:0] dwd, rd, exp_rd;
    int            lat;

    // ---------------- reset state
    do_reset();
    chk("rst_mem_req",   mem_req_o, 0);
    chk("rst_mem_we",    mem_we_o, 0);
    chk("rst_mem_be",    mem_be_o, 0);
    chk("rst_mem_addr",  mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_acks",      {inst_ack_o, data_ack_o, err_o}, 0);
    chk("rst_rdata",     {inst_rdata_o, data_rdata_o}, 0);
    chk("rst_stall",     stall_o, 0);

    // ---------------- single fetch, ack in cycle 1
    inst_req_i  = 1'b1;
    inst_addr_i = 20'h00010;
    #1 chk("sf_stall_c0", stall_o, 1);
    step();
    chk("sf_mem_req_c1", mem_req_o, 1);
    chk("sf_mem_addr",   mem_addr_o, 20'h00010);
    chk("sf_mem_be",     mem_be_o, 4'hF);
    chk("sf_mem_we",     mem_we_o, 0);
    chk("sf_stall_c1",   stall_o, 1);
    serve(0, 32'h3C08_8000);
    chk("sf_ack",        inst_ack_o, 1);
    chk("sf_rdata",      inst_rdata_o, 32'h3C08_8000);
    chk("sf_mem_req_c2", mem_req_o, 0);
    chk("sf_stall_c2",   stall_o, 0);
    inst_req_i = 1'b0;
    step();
    chk("sf_ack_gone",   inst_ack_o, 0);

    // ---------------- tie after reset: data first, then fetch
    do_reset();
    inst_req_i  = 1'b1; inst_addr_i = 20'h00100;
    data_req_i  = 1'b1; data_addr_i = 20'h00200; data_we_i = 1'b0; data_be_i = 4'hF;
    data_wdata_i = '0;
    step();
    chk("tie1_first_addr", mem_addr_o, 20'h00200);
    serve(3, 32'hAAAA_0001);
    chk("tie1_data_ack",   data_ack_o, 1);
    chk("tie1_data_rdata", data_rdata_o, 32'hAAAA_0001);
    chk("tie1_inst_noack", inst_ack_o, 0);
    data_req_i = 1'b0;
    step();
    chk("tie1_fetch_req",  mem_req_o, 1);
    chk("tie1_fetch_addr", mem_addr_o, 20'h00100);
    serve(3, 32'hBBBB_0002);
    chk("tie1_inst_ack",   inst_ack_o, 1);
    chk("tie1_inst_rdata", inst_rdata_o, 32'hBBBB_0002);
    inst_req_i = 1'b0;
    step();

    // ---------------- byte write (leaves data as last grant)
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0100;
    data_addr_i = 20'h00ABC; data_wdata_i = 32'h0011_0000;
    step();
    chk("bw_mem_we",    mem_we_o, 1);
    chk("bw_mem_be",    mem_be_o, 4'b0100);
    chk("bw_mem_addr",  mem_addr_o, 20'h00ABC);
    data_wdata_i = 32'hFFFF_FFFF;   // latched copy must not follow the input
    step();
    step();
    chk("bw_wdata_held", mem_wdata_o, 32'h0011_0000);
    serve(0, 32'hDEAD_BEEF);
    chk("bw_ack",       data_ack_o, 1);
    chk("bw_rdata",     data_rdata_o, 0);
    data_req_i = 1'b0; data_we_i = 1'b0;
    step();

    // ---------------- repeated tie: data went last, so fetch wins
    inst_req_i = 1'b1; inst_addr_i = 20'h00300;
    data_req_i = 1'b1; data_addr_i = 20'h00400; data_be_i = 4'hF;
    step();
    chk("tie2_first_addr", mem_addr_o, 20'h00300);
    serve(1, 32'h1234_5678);
    chk("tie2_inst_ack",   inst_ack_o, 1);
    inst_req_i = 1'b0;
    step();
    chk("tie2_second_addr", mem_addr_o, 20'h00400);
    serve(0, 32'h8765_4321);
    chk("tie2_data_ack",   data_ack_o, 1);
    data_req_i = 1'b0;
    step();

    // ---------------- timeout
    inst_req_i = 1'b1; inst_addr_i = 20'h003FF;
    step();
    cnt = 0;
    while (mem_req_o === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, TO);
    chk("to_ack",        inst_ack_o, 1);
    chk("to_err",        err_o, 1);
    chk("to_rdata",      inst_rdata_o, 0);
    inst_req_i = 1'b0;
    step();
    chk("to_err_pulse",  err_o, 0);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 20'h00005;
    step();
    chk("to_new_grant",  mem_req_o, 1);
    serve(0, 32'h0000_0055);
    chk("to_new_ack",    data_ack_o, 1);
    chk("to_new_noerr",  err_o, 0);
    data_req_i = 1'b0;
    step();

    // ---------------- reset in cycle 2 of a data access
    data_req_i = 1'b1; data_addr_i = 20'h00077;
    step();
    step();
    rst = 1'b0;
    data_req_i = 1'b0;
    step();
    chk("rm_mem_req",  mem_req_o, 0);
    chk("rm_outs",     {inst_ack_o, data_ack_o, err_o, mem_we_o, mem_be_o}, 0);
    chk("rm_addr",     mem_addr_o, 0);
    step();
    rst = 1'b1;
    step();
    chk("rm_no_ack",   {data_ack_o, mem_req_o}, 0);
    inst_req_i = 1'b1; inst_addr_i = 20'h00011;
    data_req_i = 1'b1; data_addr_i = 20'h00022;
    step();
    chk("rm_tie_data", mem_addr_o, 20'h00022);
    serve(0, 32'h0);
    data_req_i = 1'b0;
    step();
    serve(0, 32'h0);
    inst_req_i = 1'b0;
    step();

    // ---------------- requester drops req after grant
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 20'h00055;
    step();
    chk("dr_grant", mem_req_o, 1);
    data_req_i = 1'b0;
    serve(2, 32'hCAFE_F00D);
    chk("dr_ack",   data_ack_o, 1);
    chk("dr_rdata", data_rdata_o, 32'hCAFE_F00D);
    step();
    chk("dr_single_pulse", {data_ack_o, mem_req_o}, 0);
    step();
    chk("dr_no_regrant",   mem_req_o, 0);

    // ---------------- randomized traffic against the model
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    do_reset();
    last_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      pi  = 1'($urandom_range(0, 1));
      pd  = 1'($urandom_range(0, 1));
      if (!pi && !pd) pd = 1'b1;
      ia  = 4'($urandom_range(0, 15));
      da  = 4'($urandom_range(0, 15));
      dwe = 1'($urandom_range(0, 1));
      dbe = 4'($urandom_range(0, 15));
      dwd = $urandom;
      inst_req_i = pi; inst_addr_i = AW'(ia);
      data_req_i = pd; data_addr_i = AW'(da);
      data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd;
      first_d = (pi && pd) ? !last_m : pd;
      for (int k = 0; k < int'(pi) + int'(pd); k++) begin
        g_d = (k == 0) ? first_d : !first_d;
        step();
        chk("rnd_mem_req",   mem_req_o, 1);
        chk("rnd_mem_addr",  mem_addr_o, g_d ? AW'(da) : AW'(ia));
        chk("rnd_mem_we",    mem_we_o, g_d ? dwe : 1'b0);
        chk("rnd_mem_be",    mem_be_o, g_d ? dbe : 4'hF);
        chk("rnd_mem_wdata", mem_wdata_o, g_d ? dwd : '0);
        chk("rnd_stall",     stall_o, 1);
        lat = $urandom_range(0, 3);
        if (g_d && dwe) begin
          rd = $urandom;
          exp_rd = '0;
          for (int b = 0; b < 4; b++)
            if (dbe[b]) mem_m[da][8*b +: 8] = dwd[8*b +: 8];
        end else begin
          rd = mem_m[g_d ? da : ia];
          exp_rd = rd;
        end
        serve(lat, rd);
        st_exp = (k == 0) && pi && pd;
        chk("rnd_ack",   {inst_ack_o, data_ack_o}, g_d ? 2'b01 : 2'b10);
        chk("rnd_rdata", g_d ? data_rdata_o : inst_rdata_o, exp_rd);
        chk("rnd_err",   err_o, 0);
        chk("rnd_stall_ack", stall_o, st_exp);
        if (g_d) data_req_i = 1'b0;
        else     inst_req_i = 1'b0;
        last_m = g_d;
      end
      step();
      chk("rnd_idle", mem_req_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
